sub_8bit_serial: RTL and testbench

SUB_8BIT_SERIAL -- requirements
Module: sub_8bit_serial

---
 rtl/sub_8bit_serial.sv | 104 ++++++++++
 tb/tb_sub_8bit_serial.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sub_8bit_serial.sv
// Bit-serial 8-bit subtractor: d = a - b - b_in, one bit per cycle LSB first,
// with a valid/ready handshake on the operand side and on the result side.
module sub_8bit_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       b_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] d,
    output logic       b_out,
    output logic       ovf,
    output logic       zero,
    output logic [1:0] fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends combinationally on ready.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       br;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] sr;

    logic       a_bit;
    logic       b_bit;
    logic       d_bit;
    logic       br_next;
    logic [7:0] d_next;

    always_comb begin
        a_bit   = a_q[cnt];
        b_bit   = b_q[cnt];
        d_bit   = a_bit ^ b_bit ^ br;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        d_next  = {d_bit, sr[7:1]};
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            br        <= 1'b0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            sr        <= 8'd0;
            d         <= 8'd0;
            b_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        br       <= b_in;
                        cnt      <= 3'd0;
                        sr       <= 8'd0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Shift register is separate from d so d keeps the last result.
                    br  <= br_next;
                    sr  <= d_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        d         <= d_next;
                        b_out     <= br_next;
                        ovf       <= (a_q[7] != b_q[7]) & (d_next[7] != a_q[7]);
                        zero      <= (d_next == 8'd0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_8bit_serial.sv
// Directed bench for sub_8bit_serial: hand-computed vectors, handshake
// stalls with changing inputs, and a reset in the middle of an operation.
module tb_sub_8bit_serial;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       b_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       b_out;
    logic       ovf;
    logic       zero;
    logic [1:0] fsm_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    sub_8bit_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .b_out     (b_out),
        .ovf       (ovf),
        .zero      (zero),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand transfer; the bench keeps in_valid high for one edge only.
    task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          input logic [7:0] dexp);
        a        = av;
        b        = bv;
        b_in     = bi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(dexp);
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, 8);
    endtask

    task automatic finish_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_out_valid_after"}, out_valid, 0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi, input logic [7:0] dexp, input logic bo,
                          input logic ov, input logic z);
        logic [7:0] e;
        accept(av, bv, bi, dexp);
        wait_out(tag);
        e = exp_q.pop_front();
        check({tag, "_d"}, d, e);
        check({tag, "_b_out"}, b_out, bo);
        check({tag, "_ovf"}, ovf, ov);
        check({tag, "_zero"}, zero, z);
        finish_out(tag);
    endtask

    initial begin
        logic [7:0] e;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        b_in      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_d", d, 8'h00);
        check("rst_state", fsm_state, 0);

        run_op("v50_20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op("v00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("v05_05", 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("v05_05_bi", 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("v3c_5a", 8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1, 1'b0, 1'b0);

        // Stall in DONE with in_valid held high and operands changing throughout.
        a = 8'h3C; b = 8'h5A; b_in = 1'b1; in_valid = 1'b1;
        exp_q.push_back(8'hE1);
        tick();
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            b_in = 1'($urandom_range(0, 1));
            tick();
            if (out_valid === 1'b1) begin
                seen = i;
                break;
            end
            check("stall_run_in_ready", in_ready, 0);
        end
        check("stall_latency", seen, 8);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            b_in = 1'($urandom_range(0, 1));
            tick();
            check("stall_done_d", d, e);
            check("stall_done_b_out", b_out, 1);
            check("stall_done_zero", zero, 0);
            check("stall_done_out_valid", out_valid, 1);
            check("stall_done_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_release_state", fsm_state, 0);
        check("stall_release_in_ready", in_ready, 1);
        check("stall_release_out_valid", out_valid, 0);
        in_valid = 1'b0;
        tick();
        check("stall_no_recapture", fsm_state, 0);

        // Reset while the bit counter is at 4.
        accept(8'h77, 8'h11, 1'b0, 8'h66);
        void'(exp_q.pop_back());
        for (int i = 0; i < 4; i++) tick();
        check("abort_pre_state", fsm_state, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_state", fsm_state, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_d", d, 8'h00);
        check("abort_b_out", b_out, 0);
        check("abort_ovf", ovf, 0);
        check("abort_zero", zero, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid === 1'b1) seen = 1;
        end
        check("abort_no_out_valid", seen, 0);

        run_op("v10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
